rvfi_order_serializer: RTL and testbench



---
 rtl/rvfi_order_serializer_if.sv | 32 +++
 rtl/rvfi_order_serializer.sv | 168 ++++++++++++++++
 tb/tb_rvfi_order_serializer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/rvfi_order_serializer_if.sv
// RVFI retire-bus bundle for the order serializer.
// master drives retirements, slave is the serializer.
interface rvfi_order_serializer_if #(
  parameter int NRET      = 2,
  parameter int PAYLOAD_W = 32,
  parameter int DEPTH     = 8
);
  logic [NRET-1:0]           in_valid;
  logic [NRET*8-1:0]         in_order;
  logic [NRET*PAYLOAD_W-1:0] in_payload;
  logic                      out_valid;
  logic [7:0]                out_order;
  logic [PAYLOAD_W-1:0]      out_payload;
  logic [$clog2(DEPTH):0]    occupancy;
  logic                      overflow;
  logic                      dup_error;
  logic                      stale_error;

  modport master (
    output in_valid, in_order, in_payload,
    input  out_valid, out_order, out_payload,
    input  occupancy, overflow, dup_error,
    input  stale_error
  );

  modport slave (
    input  in_valid, in_order, in_payload,
    output out_valid, out_order, out_payload,
    output occupancy, overflow, dup_error,
    output stale_error
  );
endinterface

// File: rtl/rvfi_order_serializer.sv
// Buffers up to NRET retirements per cycle and
// replays them one per cycle in rvfi_order sequence.
module rvfi_order_serializer #(
  parameter int NRET      = 2,
  parameter int PAYLOAD_W = 32,
  parameter int DEPTH     = 8
) (
  input  logic clk,
  input  logic reset,
  rvfi_order_serializer_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int OW = IW + 1;

  logic [DEPTH-1:0]     r_used;
  logic [7:0]           r_ord [DEPTH];
  logic [PAYLOAD_W-1:0] r_pay [DEPTH];
  logic [7:0]           r_next;
  logic                 r_ovalid;
  logic [7:0]           r_oord;
  logic [PAYLOAD_W-1:0] r_opay;
  logic [OW-1:0]        r_occ;
  logic                 r_ovf;
  logic                 r_dup;
  logic                 r_stale;

  logic          w_hit;
  logic [IW-1:0] w_didx;

  always_comb begin
    w_hit  = 1'b0;
    w_didx = '0;
    for (int s = 0; s < DEPTH; s++) begin
      if (!w_hit && r_used[s] &&
          r_ord[s] == r_next) begin
        w_hit  = 1'b1;
        w_didx = IW'(s);
      end
    end
  end

  logic [NRET-1:0]  w_acc;
  logic [IW-1:0]    w_slot [NRET];
  logic [DEPTH-1:0] w_free;
  logic [DEPTH-1:0] w_alloc;
  logic [7:0]       w_ord;
  logic [7:0]       w_diff;
  logic             w_dup;
  logic             w_found;
  logic             w_set_ovf;
  logic             w_set_dup;
  logic             w_set_stale;

  // Channels claim the lowest free slot in index order;
  // only slots unused before this edge are eligible.
  always_comb begin
    w_acc       = '0;
    w_free      = ~r_used;
    w_alloc     = '0;
    w_ord       = '0;
    w_diff      = '0;
    w_dup       = 1'b0;
    w_found     = 1'b0;
    w_set_ovf   = 1'b0;
    w_set_dup   = 1'b0;
    w_set_stale = 1'b0;
    for (int c = 0; c < NRET; c++)
      w_slot[c] = '0;
    for (int c = 0; c < NRET; c++) begin
      w_ord   = bus.in_order[c*8 +: 8];
      w_diff  = w_ord - r_next;
      w_dup   = 1'b0;
      w_found = 1'b0;
      if (bus.in_valid[c]) begin
        if (w_diff[7]) begin
          w_set_stale = 1'b1;
        end else begin
          for (int s = 0; s < DEPTH; s++)
            if (r_used[s] && r_ord[s] == w_ord)
              w_dup = 1'b1;
          for (int k = 0; k < c; k++)
            if (w_acc[k] &&
                bus.in_order[k*8 +: 8] == w_ord)
              w_dup = 1'b1;
          if (w_dup) begin
            w_set_dup = 1'b1;
          end else begin
            for (int s = 0; s < DEPTH; s++) begin
              if (!w_found && w_free[s]) begin
                w_found   = 1'b1;
                w_slot[c] = IW'(s);
              end
            end
            if (w_found) begin
              w_acc[c]          = 1'b1;
              w_free[w_slot[c]] = 1'b0;
              w_alloc[w_slot[c]] = 1'b1;
            end else begin
              w_set_ovf = 1'b1;
            end
          end
        end
      end
    end
  end

  logic [DEPTH-1:0] w_dmask;
  logic [DEPTH-1:0] w_used_nxt;
  logic [OW-1:0]    w_cnt;

  always_comb begin
    w_dmask = '0;
    if (w_hit)
      w_dmask[w_didx] = 1'b1;
    w_used_nxt = (r_used & ~w_dmask) | w_alloc;
    w_cnt = '0;
    for (int s = 0; s < DEPTH; s++)
      w_cnt = w_cnt + OW'(w_used_nxt[s]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_used   <= '0;
      r_next   <= '0;
      r_ovalid <= 1'b0;
      r_oord   <= '0;
      r_opay   <= '0;
      r_occ    <= '0;
      r_ovf    <= 1'b0;
      r_dup    <= 1'b0;
      r_stale  <= 1'b0;
    end else begin
      r_used   <= w_used_nxt;
      r_occ    <= w_cnt;
      r_ovalid <= w_hit;
      if (w_hit) begin
        r_oord <= r_ord[w_didx];
        r_opay <= r_pay[w_didx];
        r_next <= r_next + 8'd1;
      end
      r_ovf   <= r_ovf   | w_set_ovf;
      r_dup   <= r_dup   | w_set_dup;
      r_stale <= r_stale | w_set_stale;
    end
  end

  // Slot contents are qualified by r_used, so no reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NRET; c++) begin
        if (w_acc[c]) begin
          r_ord[w_slot[c]] <=
            bus.in_order[c*8 +: 8];
          r_pay[w_slot[c]] <=
            bus.in_payload[c*PAYLOAD_W +: PAYLOAD_W];
        end
      end
    end
  end

  assign bus.out_valid   = r_ovalid;
  assign bus.out_order   = r_oord;
  assign bus.out_payload = r_opay;
  assign bus.occupancy   = r_occ;
  assign bus.overflow    = r_ovf;
  assign bus.dup_error   = r_dup;
  assign bus.stale_error = r_stale;
endmodule

// File: tb/tb_rvfi_order_serializer.sv
// Vector table plus ordered scoreboard for
// rvfi_order_serializer (NRET=2, DEPTH=8).
module tb_rvfi_order_serializer;
  logic clk;
  logic reset;

  rvfi_order_serializer_if #(
    .NRET(2), .PAYLOAD_W(32), .DEPTH(8)
  ) bus ();

  rvfi_order_serializer #(
    .NRET(2), .PAYLOAD_W(32), .DEPTH(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [7:0]  o;
    logic [31:0] p;
  } exp_t;
  exp_t sb[$];

  typedef struct packed {
    logic       rst;
    logic [1:0] v;
    logic [7:0] a;
    logic [7:0] b;
    logic       ev;
    logic [7:0] eo;
    logic [3:0] eocc;
  } vec_t;
  vec_t tbl[13];

  function automatic logic [31:0] pay(
    input int ch, input logic [7:0] o);
    logic [7:0] tag;
    tag = 8'hA0 + 8'(ch);
    return {tag, 8'h5A, 8'h3C, o};
  endfunction

  task automatic chk(input string nm,
    input logic [31:0] act,
    input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v,
    input logic [7:0] a, input logic [7:0] b,
    input logic r);
    bus.in_valid   = v;
    bus.in_order   = {b, a};
    bus.in_payload = {pay(1, b), pay(0, a)};
    reset          = r;
    @(posedge clk);
    #1;
    bus.in_valid = '0;
    reset        = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(2'b00, 8'd0, 8'd0, 1'b0);
  endtask

  task automatic push(input logic [7:0] o,
    input int ch);
    sb.push_back('{o: o, p: pay(ch, o)});
  endtask

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got order %0d expected none",
                 bus.out_order);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_order", 32'(bus.out_order), 32'(e.o));
        chk("sb_payload", bus.out_payload, e.p);
      end
    end
  end

  initial begin
    bus.in_valid   = '0;
    bus.in_order   = '0;
    bus.in_payload = '0;
    reset          = 1'b1;

    tbl[0]  = '{1'b1, 2'b00, 8'd0, 8'd0, 1'b0, 8'd0, 4'd0};
    tbl[1]  = '{1'b0, 2'b01, 8'd0, 8'd0, 1'b0, 8'd0, 4'd1};
    tbl[2]  = '{1'b0, 2'b01, 8'd1, 8'd0, 1'b1, 8'd0, 4'd1};
    tbl[3]  = '{1'b0, 2'b01, 8'd2, 8'd0, 1'b1, 8'd1, 4'd1};
    tbl[4]  = '{1'b0, 2'b00, 8'd0, 8'd0, 1'b1, 8'd2, 4'd0};
    tbl[5]  = '{1'b0, 2'b00, 8'd0, 8'd0, 1'b0, 8'd2, 4'd0};
    tbl[6]  = '{1'b1, 2'b00, 8'd0, 8'd0, 1'b0, 8'd0, 4'd0};
    tbl[7]  = '{1'b0, 2'b11, 8'd1, 8'd0, 1'b0, 8'd0, 4'd2};
    tbl[8]  = '{1'b0, 2'b11, 8'd3, 8'd2, 1'b1, 8'd0, 4'd3};
    tbl[9]  = '{1'b0, 2'b00, 8'd0, 8'd0, 1'b1, 8'd1, 4'd2};
    tbl[10] = '{1'b0, 2'b00, 8'd0, 8'd0, 1'b1, 8'd2, 4'd1};
    tbl[11] = '{1'b0, 2'b00, 8'd0, 8'd0, 1'b1, 8'd3, 4'd0};
    tbl[12] = '{1'b0, 2'b00, 8'd0, 8'd0, 1'b0, 8'd3, 4'd0};

    push(8'd0, 0); push(8'd1, 0); push(8'd2, 0);
    push(8'd0, 1); push(8'd1, 0);
    push(8'd2, 1); push(8'd3, 0);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].rst);
      chk($sformatf("v%0d_valid", i),
          32'(bus.out_valid), 32'(tbl[i].ev));
      chk($sformatf("v%0d_order", i),
          32'(bus.out_order), 32'(tbl[i].eo));
      chk($sformatf("v%0d_occ", i),
          32'(bus.occupancy), 32'(tbl[i].eocc));
      chk($sformatf("v%0d_flags", i),
          32'({bus.overflow, bus.dup_error,
               bus.stale_error}), 32'd0);
      if (tbl[i].rst)
        chk($sformatf("v%0d_payload", i),
            bus.out_payload, 32'd0);
    end
    chk("tbl_sb_empty", 32'(sb.size()), 32'd0);

    // Overflow with order 0 withheld.
    drive(2'b00, 8'd0, 8'd0, 1'b1);
    drive(2'b11, 8'd1, 8'd2, 1'b0);
    drive(2'b11, 8'd3, 8'd4, 1'b0);
    drive(2'b11, 8'd5, 8'd6, 1'b0);
    drive(2'b11, 8'd7, 8'd8, 1'b0);
    chk("ovf_occ_full", 32'(bus.occupancy), 32'd8);
    chk("ovf_not_yet", 32'(bus.overflow), 32'd0);
    drive(2'b11, 8'd9, 8'd10, 1'b0);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    chk("ovf_occ_hold", 32'(bus.occupancy), 32'd8);
    chk("ovf_no_out", 32'(bus.out_valid), 32'd0);
    drive(2'b01, 8'd0, 8'd0, 1'b0);
    idle(2);
    chk("ovf_stuck_out", 32'(bus.out_valid), 32'd0);
    chk("ovf_stuck_occ", 32'(bus.occupancy), 32'd8);
    chk("ovf_other_flags",
        32'({bus.dup_error, bus.stale_error}), 32'd0);

    // Same-cycle duplicate of order 5.
    drive(2'b00, 8'd0, 8'd0, 1'b1);
    chk("rst_clears_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_clears_occ", 32'(bus.occupancy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      push(8'(i), 0);
      drive(2'b01, 8'(i), 8'd0, 1'b0);
    end
    idle(3);
    push(8'd5, 0);
    drive(2'b11, 8'd5, 8'd5, 1'b0);
    chk("dup_set", 32'(bus.dup_error), 32'd1);
    chk("dup_occ", 32'(bus.occupancy), 32'd1);
    chk("dup_no_stale", 32'(bus.stale_error), 32'd0);
    drive(2'b00, 8'd0, 8'd0, 1'b0);
    chk("dup_out_valid", 32'(bus.out_valid), 32'd1);
    idle(2);
    chk("dup_occ_end", 32'(bus.occupancy), 32'd0);
    chk("dup_sb_empty", 32'(sb.size()), 32'd0);

    // Walk next_order to 250, then wrap.
    drive(2'b00, 8'd0, 8'd0, 1'b1);
    for (int i = 0; i < 250; i++) begin
      push(8'(i), 0);
      drive(2'b01, 8'(i), 8'd0, 1'b0);
    end
    idle(3);
    chk("wrap_pre_empty", 32'(sb.size()), 32'd0);
    push(8'd250, 0); push(8'd251, 1);
    push(8'd252, 0); push(8'd253, 1);
    push(8'd254, 0); push(8'd255, 1);
    push(8'd0, 0);   push(8'd1, 1);
    drive(2'b11, 8'd250, 8'd251, 1'b0);
    drive(2'b11, 8'd252, 8'd253, 1'b0);
    drive(2'b11, 8'd254, 8'd255, 1'b0);
    drive(2'b11, 8'd0, 8'd1, 1'b0);
    idle(8);
    chk("wrap_sb_empty", 32'(sb.size()), 32'd0);
    chk("wrap_last", 32'(bus.out_order), 32'd1);
    chk("wrap_no_flags",
        32'({bus.overflow, bus.dup_error,
             bus.stale_error}), 32'd0);
    drive(2'b01, 8'd200, 8'd0, 1'b0);
    chk("stale_set", 32'(bus.stale_error), 32'd1);
    chk("stale_occ", 32'(bus.occupancy), 32'd0);
    idle(2);
    chk("stale_no_out", 32'(bus.out_valid), 32'd0);

    // Reset mid-stream with entries buffered.
    drive(2'b00, 8'd0, 8'd0, 1'b1);
    drive(2'b11, 8'd1, 8'd2, 1'b0);
    push(8'd0, 0);
    drive(2'b11, 8'd0, 8'd3, 1'b0);
    chk("mid_occ4", 32'(bus.occupancy), 32'd4);
    drive(2'b00, 8'd0, 8'd0, 1'b0);
    chk("mid_valid", 32'(bus.out_valid), 32'd1);
    chk("mid_occ3", 32'(bus.occupancy), 32'd3);
    drive(2'b01, 8'd4, 8'd0, 1'b1);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_order", 32'(bus.out_order), 32'd0);
    chk("mid_rst_pay", bus.out_payload, 32'd0);
    chk("mid_rst_occ", 32'(bus.occupancy), 32'd0);
    push(8'd0, 1);
    drive(2'b10, 8'd0, 8'd0, 1'b0);
    chk("post_rst_lat1", 32'(bus.out_valid), 32'd0);
    drive(2'b00, 8'd0, 8'd0, 1'b0);
    chk("post_rst_lat2", 32'(bus.out_valid), 32'd1);
    chk("post_rst_order", 32'(bus.out_order), 32'd0);
    idle(2);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
